pmem_arbiter: RTL and testbench
===============================

# pmem_arbiter

Two-port arbiter that shares the single 256-bit physical-memory port between an instruction-cache and a data-cache requester. It sits between the two caches and physical memory in the split-cache top level, with the same pmem handshake on every side. It latches one line transaction at a time, forwards it to memory, and routes the response back to the requester that owns it. Arbitration is round-robin by default, or fixed data-cache priority when configured.

## Interface

Parameters:
- ADDR_WIDTH, 32: address width of requesters and memory.
- LINE_WIDTH, 256: cache-line data width.
- D_PRIORITY, 0: 0 selects round-robin; 1 makes the data cache always win ties.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_read / i_write  in  1  instruction-cache line read and write requests, level, held until i_resp.
- i_address  in  ADDR_WIDTH  instruction-cache line address.
- i_wdata  in  LINE_WIDTH  instruction-cache write line.
- i_resp  out  1  one-cycle completion pulse to the instruction cache.
- i_rdata  out  LINE_WIDTH  read line to the instruction cache.
- d_read, d_write, d_address, d_wdata, d_resp, d_rdata: same as the i_* ports, for the data cache.
- pmem_resp  in  1  memory completion pulse.
- pmem_rdata  in  LINE_WIDTH  memory read line.
- pmem_read / pmem_write  out  1  registered memory request strobes.
- pmem_address  out  ADDR_WIDTH  registered line address.
- pmem_wdata  out  LINE_WIDTH  registered write line.

## Operation

States: IDLE, SERVE_I, SERVE_D.

IDLE:
- i_req = i_read | i_write; d_req = d_read | d_write.
- Only one request present: grant that requester.
- Both present with D_PRIORITY=1: grant D.
- Both present with D_PRIORITY=0: grant the requester opposite to last_grant.
- On a grant, at the edge, capture into output registers:
  - address, with bits [4:0] forced to 0;
  - wdata;
  - the op: write if the requester's write is 1, else read. Read and write both asserted is treated as a write.
- On a grant, also set last_grant and move to SERVE_I or SERVE_D.

SERVE_x:
- pmem_read or pmem_write is held at 1 from the registers.
- Requester inputs are ignored, including deassertion or changes mid-service. The transaction always completes.
- When pmem_resp=1:
  - x_resp=1 combinationally in the same cycle;
  - on that edge, clear pmem_read and pmem_write and return to IDLE.

Response routing:
- x_rdata = pmem_rdata combinationally, regardless of state.
- The non-owner's resp is always 0.

## Timing

- Reset value of every output (asserted asynchronously):
  - pmem_read = pmem_write = 0; pmem_address = 0; pmem_wdata = 0.
  - i_resp = d_resp = 0.
- Reset value of internal state: state = IDLE; last_grant = D, so the first tie goes to I under round-robin.
- Grant latency:
  - a request seen in IDLE at edge N drives pmem strobes from cycle N+1;
  - minimum request-to-resp latency is 1 cycle plus memory latency.
- pmem_resp in the cycle the strobe first rises is legal and completes the transaction in that cycle.
- Back-to-back transactions:
  - after the resp cycle, the arbiter spends exactly one cycle in IDLE before re-driving a strobe;
  - pmem strobes are low for at least one cycle between transactions.
- Requesters deassert their request on the edge after their resp, so a completed requester is not re-granted in the IDLE cycle.
- pmem_resp while in IDLE is ignored: no x_resp, no state change.
- Reset mid-transaction aborts immediately: strobes drop and no resp is issued. Memory-side cleanup is the system's responsibility.
- Starvation bound (round-robin): a pending requester is granted within one other transaction.

## Test plan

- Single I read:
  - i_read=1, i_address=0x0000_0064;
  - pmem_read=1 with pmem_address=0x0000_0060 one cycle later;
  - pmem_resp after 3 cycles with rdata=0xAA..AA → i_resp pulses 1 cycle and i_rdata=0xAA..AA;
  - d_resp stays 0.
- Simultaneous requests, D_PRIORITY=0:
  - i_read and d_write asserted together from reset → I served first, then D;
  - the D transaction carries the registered d_wdata;
  - the next tie goes to I again only after D has been served.
- Simultaneous requests, D_PRIORITY=1: both pending repeatedly → D is served every tie; I is served only when d_req=0.
- Mid-service change:
  - during SERVE_D, change d_address to 0x100 and assert i_read;
  - pmem_address is unchanged, the D transaction completes, then I is granted.
- Reset mid-operation:
  - assert rst_n=0 while pmem_write=1 → all outputs are 0 immediately, without waiting for a clock edge;
  - after release, a fresh i_read proceeds normally.
- Spurious and overlapping inputs:
  - pmem_resp pulsed in IDLE → no resp output;
  - d_read and d_write both 1 → pmem_write=1 and pmem_read=0.

Source files
------------

// File: rtl/pmem_arbiter.sv
// pmem_arbiter: shares one cache-line physical-memory port between an
// instruction-cache requester and a data-cache requester. One line
// transaction is latched at a time, forwarded to memory through registered
// strobes, and the memory response is routed back to the requester that
// owns the transaction.
//
// Handshake (identical on every side): a requester raises read or write as a
// level together with a stable address/wdata and holds it until it sees a
// one-cycle resp pulse; the responder asserts resp for exactly one cycle when
// the line transfer is complete, and rdata is valid in that same cycle.
module pmem_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_WIDTH = 256,
   parameter int D_PRIORITY = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,

   // instruction-cache side
   input  logic                  i_read,
   input  logic                  i_write,
   input  logic [ADDR_WIDTH-1:0] i_address,
   input  logic [LINE_WIDTH-1:0] i_wdata,
   output logic                  i_resp,
   output logic [LINE_WIDTH-1:0] i_rdata,

   // data-cache side
   input  logic                  d_read,
   input  logic                  d_write,
   input  logic [ADDR_WIDTH-1:0] d_address,
   input  logic [LINE_WIDTH-1:0] d_wdata,
   output logic                  d_resp,
   output logic [LINE_WIDTH-1:0] d_rdata,

   // physical-memory side
   input  logic                  pmem_resp,
   input  logic [LINE_WIDTH-1:0] pmem_rdata,
   output logic                  pmem_read,
   output logic                  pmem_write,
   output logic [ADDR_WIDTH-1:0] pmem_address,
   output logic [LINE_WIDTH-1:0] pmem_wdata,

   // current arbiter state for observation (IDLE=0, SERVE_I=1, SERVE_D=2)
   output logic [1:0]            state_dbg
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2
   } state_t;

   state_t state;
   state_t state_next;

   // 1 when the most recent grant went to the data cache
   logic last_grant_d;
   logic last_grant_d_next;

   logic i_req;
   logic d_req;
   logic grant_i;
   logic grant_d;

   logic [ADDR_WIDTH-1:0] grant_address;
   logic [LINE_WIDTH-1:0] grant_wdata;
   logic                  grant_write;

   assign i_req = i_read | i_write;
   assign d_req = d_read | d_write;

   // Read data is broadcast; only the owner's resp qualifies it.
   assign i_rdata = pmem_rdata;
   assign d_rdata = pmem_rdata;

   // The response is combinational from pmem_resp, gated by ownership, so a
   // resp seen while idle never reaches either requester.
   assign i_resp = (state == SERVE_I) & pmem_resp;
   assign d_resp = (state == SERVE_D) & pmem_resp;

   assign state_dbg = state;

   // Arbitration: grants are only made from IDLE; ties go to D under fixed
   // priority, otherwise to whichever requester did not win last time.
   always_comb begin
      grant_i = 1'b0;
      grant_d = 1'b0;
      if (state == IDLE) begin
         if (i_req && d_req) begin
            if ((D_PRIORITY != 0) || !last_grant_d) begin
               grant_d = 1'b1;
            end else begin
               grant_i = 1'b1;
            end
         end else if (d_req) begin
            grant_d = 1'b1;
         end else if (i_req) begin
            grant_i = 1'b1;
         end
      end
   end

   // Select the winning requester's transaction; the address is line-aligned
   // and a simultaneous read+write is issued as a write.
   always_comb begin
      grant_address = i_address;
      grant_wdata   = i_wdata;
      grant_write   = i_write;
      if (grant_d) begin
         grant_address = d_address;
         grant_wdata   = d_wdata;
         grant_write   = d_write;
      end
      grant_address[4:0] = 5'd0;
   end

   // Next-state logic: grant from IDLE, return to IDLE on the memory resp.
   always_comb begin
      state_next        = state;
      last_grant_d_next = last_grant_d;
      case (state)
         IDLE: begin
            if (grant_d) begin
               state_next        = SERVE_D;
               last_grant_d_next = 1'b1;
            end else if (grant_i) begin
               state_next        = SERVE_I;
               last_grant_d_next = 1'b0;
            end
         end
         SERVE_I: begin
            if (pmem_resp) begin
               state_next = IDLE;
            end
         end
         SERVE_D: begin
            if (pmem_resp) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State register; reset leaves last_grant on D so the first tie goes to I.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         last_grant_d <= 1'b1;
      end else begin
         state        <= state_next;
         last_grant_d <= last_grant_d_next;
      end
   end

   // Memory request registers: loaded on a grant, strobes dropped on resp.
   // Address and wdata keep the last transaction's values until the next grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pmem_read    <= 1'b0;
         pmem_write   <= 1'b0;
         pmem_address <= '0;
         pmem_wdata   <= '0;
      end else if (grant_i || grant_d) begin
         pmem_read    <= ~grant_write;
         pmem_write   <= grant_write;
         pmem_address <= grant_address;
         pmem_wdata   <= grant_wdata;
      end else if ((state != IDLE) && pmem_resp) begin
         pmem_read    <= 1'b0;
         pmem_write   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Testbench for pmem_arbiter: instance 0 is round-robin, instance 1 uses
// fixed data-cache priority. A transaction-level model checks every output
// each cycle; a per-instance expected queue pins the order and content of
// completed transactions with hand-computed values.
module tb_pmem_arbiter;

   localparam int AW = 32;
   localparam int LW = 256;
   localparam int EW = 50; // {owner_d, write, address[31:0], wdata[15:0]}

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT signals (index = instance) ----------------
   logic          i_read [2];
   logic          i_write [2];
   logic [AW-1:0] i_address [2];
   logic [LW-1:0] i_wdata [2];
   logic          i_resp [2];
   logic [LW-1:0] i_rdata [2];
   logic          d_read [2];
   logic          d_write [2];
   logic [AW-1:0] d_address [2];
   logic [LW-1:0] d_wdata [2];
   logic          d_resp [2];
   logic [LW-1:0] d_rdata [2];
   logic          pmem_resp [2];
   logic [LW-1:0] pmem_rdata [2];
   logic          pmem_read [2];
   logic          pmem_write [2];
   logic [AW-1:0] pmem_address [2];
   logic [LW-1:0] pmem_wdata [2];
   logic [1:0]    state_dbg [2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      pmem_arbiter #(
         .ADDR_WIDTH (AW),
         .LINE_WIDTH (LW),
         .D_PRIORITY (g)
      ) dut (
         .clk          (clk),
         .rst_n        (rst_n),
         .i_read       (i_read[g]),
         .i_write      (i_write[g]),
         .i_address    (i_address[g]),
         .i_wdata      (i_wdata[g]),
         .i_resp       (i_resp[g]),
         .i_rdata      (i_rdata[g]),
         .d_read       (d_read[g]),
         .d_write      (d_write[g]),
         .d_address    (d_address[g]),
         .d_wdata      (d_wdata[g]),
         .d_resp       (d_resp[g]),
         .d_rdata      (d_rdata[g]),
         .pmem_resp    (pmem_resp[g]),
         .pmem_rdata   (pmem_rdata[g]),
         .pmem_read    (pmem_read[g]),
         .pmem_write   (pmem_write[g]),
         .pmem_address (pmem_address[g]),
         .pmem_wdata   (pmem_wdata[g]),
         .state_dbg    (state_dbg[g])
      );
   end

   // ---------------- counters / check helper ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- memory and requester agents ----------------
   int mem_lat [2];
   int mem_cnt [2];
   bit i_seen [2];
   bit d_seen [2];

   // remember which requester completed in the cycle just ending
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         i_seen[k] = i_resp[k];
         d_seen[k] = d_resp[k];
      end
   end

   // requesters drop their request on the edge after resp; memory answers
   // mem_lat cycles after its strobe first rises (0 = same cycle)
   always @(posedge clk) begin
      #1;
      for (int k = 0; k < 2; k++) begin
         if (i_seen[k]) begin
            i_read[k]  = 1'b0;
            i_write[k] = 1'b0;
         end
         if (d_seen[k]) begin
            d_read[k]  = 1'b0;
            d_write[k] = 1'b0;
         end
         if (!rst_n) begin
            mem_cnt[k]   = 0;
            pmem_resp[k] = 1'b0;
         end else if (pmem_read[k] || pmem_write[k]) begin
            if (mem_cnt[k] == mem_lat[k]) begin
               pmem_resp[k] = 1'b1;
               mem_cnt[k]   = 0;
            end else begin
               pmem_resp[k] = 1'b0;
               mem_cnt[k]++;
            end
         end else begin
            pmem_resp[k] = 1'b0;
            mem_cnt[k]   = 0;
         end
      end
   end

   // ---------------- transaction-level model ----------------
   bit            m_busy [2];
   bit            m_own_d [2];
   bit            m_wr [2];
   bit            m_last_d [2];
   logic [AW-1:0] m_addr [2];
   logic [LW-1:0] m_wdata [2];

   always @(posedge clk or negedge rst_n) begin
      for (int k = 0; k < 2; k++) begin
         if (!rst_n) begin
            m_busy[k]   = 1'b0;
            m_own_d[k]  = 1'b0;
            m_wr[k]     = 1'b0;
            m_last_d[k] = 1'b1;
            m_addr[k]   = '0;
            m_wdata[k]  = '0;
         end else if (m_busy[k]) begin
            if (pmem_resp[k]) m_busy[k] = 1'b0;
         end else begin
            bit ir;
            bit dr;
            bit take_d;
            ir = i_read[k] || i_write[k];
            dr = d_read[k] || d_write[k];
            if (ir || dr) begin
               // instance 1 favours D on ties; instance 0 alternates
               take_d = dr && (!ir || (k == 1) || !m_last_d[k]);
               m_busy[k]   = 1'b1;
               m_own_d[k]  = take_d;
               m_last_d[k] = take_d;
               m_wr[k]     = take_d ? d_write[k] : i_write[k];
               m_addr[k]   = (take_d ? d_address[k] : i_address[k]) & ~32'h1F;
               m_wdata[k]  = take_d ? d_wdata[k] : i_wdata[k];
            end
         end
      end
   end

   // every-cycle comparison of all outputs against the model
   always @(negedge clk) begin
      if (rst_n) begin
         for (int k = 0; k < 2; k++) begin
            chk($sformatf("pmem_read[%0d]", k), pmem_read[k], m_busy[k] && !m_wr[k]);
            chk($sformatf("pmem_write[%0d]", k), pmem_write[k], m_busy[k] && m_wr[k]);
            chk($sformatf("pmem_address[%0d]", k), pmem_address[k], m_addr[k]);
            chk($sformatf("pmem_wdata[%0d]", k), pmem_wdata[k], m_wdata[k]);
            chk($sformatf("i_resp[%0d]", k), i_resp[k], m_busy[k] && !m_own_d[k] && pmem_resp[k]);
            chk($sformatf("d_resp[%0d]", k), d_resp[k], m_busy[k] && m_own_d[k] && pmem_resp[k]);
            chk($sformatf("i_rdata[%0d]", k), i_rdata[k], pmem_rdata[k]);
            chk($sformatf("d_rdata[%0d]", k), d_rdata[k], pmem_rdata[k]);
            chk($sformatf("state_busy[%0d]", k), state_dbg[k] != 2'd0, m_busy[k]);
         end
      end
   end

   // ---------------- scoreboard: expected completed transactions ----------------
   logic [EW-1:0] exp_q0 [$];
   logic [EW-1:0] exp_q1 [$];

   task automatic push(input int k, input logic [EW-1:0] e);
      if (k == 0) exp_q0.push_back(e);
      else        exp_q1.push_back(e);
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         for (int k = 0; k < 2; k++) begin
            if (i_resp[k] || d_resp[k]) begin
               logic [EW-1:0] got;
               logic [EW-1:0] exp;
               bit            have;
               got  = {d_resp[k], pmem_write[k], pmem_address[k], pmem_wdata[k][15:0]};
               have = (k == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0);
               if (!have) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL sb_unexpected[%0d]: got transaction %0h, expected none", k, got);
               end else begin
                  exp = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                  chk($sformatf("sb_txn[%0d]", k), got, exp);
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic req_i(input int k, input bit rd, input bit wr, input logic [AW-1:0] a,
                        input logic [LW-1:0] w);
      i_read[k]    = rd;
      i_write[k]   = wr;
      i_address[k] = a;
      i_wdata[k]   = w;
   endtask

   task automatic req_d(input int k, input bit rd, input bit wr, input logic [AW-1:0] a,
                        input logic [LW-1:0] w);
      d_read[k]    = rd;
      d_write[k]   = wr;
      d_address[k] = a;
      d_wdata[k]   = w;
   endtask

   task automatic wait_idle(input int k);
      for (int n = 0; n < 60; n++) begin
         tick();
         if (!(i_read[k] || i_write[k] || d_read[k] || d_write[k] ||
               pmem_read[k] || pmem_write[k])) return;
      end
      n_checks++;
      n_fail++;
      $display("FAIL wait_idle[%0d]: still busy after 60 cycles, expected idle", k);
   endtask

   task automatic wait_resp(input int k, input bit is_d);
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < 40 && !seen; n++) begin
         @(negedge clk);
         seen = is_d ? d_resp[k] : i_resp[k];
      end
      if (!seen) begin
         n_checks++;
         n_fail++;
         $display("FAIL wait_resp[%0d]: no resp within 40 cycles, expected one", k);
      end
   endtask

   task automatic clear_inputs();
      for (int k = 0; k < 2; k++) begin
         req_i(k, 1'b0, 1'b0, '0, '0);
         req_d(k, 1'b0, 1'b0, '0, '0);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      clear_inputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed stimulus ----------------
   initial begin
      clear_inputs();
      for (int k = 0; k < 2; k++) begin
         pmem_resp[k]  = 1'b0;
         pmem_rdata[k] = '0;
         mem_lat[k]    = 2;
         mem_cnt[k]    = 0;
      end

      // reset values while reset is held
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("rst_pmem_read", pmem_read[k], 0);
         chk("rst_pmem_write", pmem_write[k], 0);
         chk("rst_pmem_address", pmem_address[k], 0);
         chk("rst_pmem_wdata", pmem_wdata[k], 0);
         chk("rst_i_resp", i_resp[k], 0);
         chk("rst_d_resp", d_resp[k], 0);
      end
      @(negedge clk);
      rst_n = 1'b1;

      // single I read, memory answers 3 cycles after the strobe
      mem_lat[0]    = 3;
      pmem_rdata[0] = {32{8'hAA}};
      tick();
      req_i(0, 1'b1, 1'b0, 32'h0000_0064, '0);
      push(0, {1'b0, 1'b0, 32'h0000_0060, 16'h0000});
      tick();
      chk("t1_pmem_read", pmem_read[0], 1);
      chk("t1_pmem_address", pmem_address[0], 32'h0000_0060);
      wait_resp(0, 1'b0);
      chk("t1_i_resp", i_resp[0], 1);
      chk("t1_i_rdata", i_rdata[0], {32{8'hAA}});
      chk("t1_d_resp", d_resp[0], 0);
      @(negedge clk);
      chk("t1_i_resp_pulse", i_resp[0], 0);
      wait_idle(0);

      // round-robin ties from reset: I, then D; next tie goes to I again
      do_reset();
      mem_lat[0]    = 1;
      pmem_rdata[0] = {64{4'h5}};
      tick();
      req_i(0, 1'b1, 1'b0, 32'h0000_1000, '0);
      req_d(0, 1'b0, 1'b1, 32'h0000_2004, {8{32'hD00D_0001}});
      push(0, {1'b0, 1'b0, 32'h0000_1000, 16'h0000});
      push(0, {1'b1, 1'b1, 32'h0000_2000, 16'h0001});
      wait_idle(0);
      req_i(0, 1'b0, 1'b1, 32'h0000_1100, {8{32'h1111_0002}});
      req_d(0, 1'b1, 1'b0, 32'h0000_2100, '0);
      push(0, {1'b0, 1'b1, 32'h0000_1100, 16'h0002});
      push(0, {1'b1, 1'b0, 32'h0000_2100, 16'h0000});
      wait_idle(0);

      // fixed D priority: D wins every tie, I served once D is gone
      mem_lat[1]    = 0;
      pmem_rdata[1] = {8{32'h1234_5678}};
      req_i(1, 1'b1, 1'b0, 32'h0000_8000, '0);
      req_d(1, 1'b1, 1'b0, 32'h0000_9000, '0);
      push(1, {1'b1, 1'b0, 32'h0000_9000, 16'h0000});
      push(1, {1'b0, 1'b0, 32'h0000_8000, 16'h0000});
      wait_idle(1);
      mem_lat[1] = 2;
      req_i(1, 1'b0, 1'b1, 32'h0000_8100, {8{32'h0000_0002}});
      req_d(1, 1'b0, 1'b1, 32'h0000_9100, {8{32'h0000_0003}});
      push(1, {1'b1, 1'b1, 32'h0000_9100, 16'h0003});
      push(1, {1'b0, 1'b1, 32'h0000_8100, 16'h0002});
      wait_idle(1);
      req_i(1, 1'b1, 1'b0, 32'h0000_A01F, '0);
      push(1, {1'b0, 1'b0, 32'h0000_A000, 16'h0000});
      wait_idle(1);

      // requester inputs change mid-service; D completes, then I is granted
      mem_lat[0] = 4;
      req_d(0, 1'b1, 1'b0, 32'h0000_3000, '0);
      push(0, {1'b1, 1'b0, 32'h0000_3000, 16'h0000});
      push(0, {1'b0, 1'b0, 32'h0000_4000, 16'h0000});
      tick();
      d_address[0] = 32'h0000_0100;
      req_i(0, 1'b1, 1'b0, 32'h0000_4000, '0);
      tick();
      chk("t4_pmem_address_held", pmem_address[0], 32'h0000_3000);
      chk("t4_pmem_read_held", pmem_read[0], 1);
      wait_idle(0);

      // spurious pmem_resp in IDLE, then read+write issued as a write
      tick();
      #1;
      pmem_resp[1] = 1'b1;
      @(negedge clk);
      chk("t5_spurious_d_resp", d_resp[1], 0);
      chk("t5_spurious_i_resp", i_resp[1], 0);
      tick();
      req_d(1, 1'b1, 1'b1, 32'h0000_5010, {8{32'h0000_0005}});
      push(1, {1'b1, 1'b1, 32'h0000_5000, 16'h0005});
      tick();
      chk("t5_rw_pmem_write", pmem_write[1], 1);
      chk("t5_rw_pmem_read", pmem_read[1], 0);
      wait_idle(1);

      // asynchronous reset while a write is in flight
      mem_lat[0] = 6;
      req_i(0, 1'b0, 1'b1, 32'h0000_6000, {8{32'h0000_0006}});
      tick();
      chk("t6_pmem_write_before", pmem_write[0], 1);
      tick();
      #1;
      rst_n = 1'b0;
      #1;
      chk("t6_async_pmem_write", pmem_write[0], 0);
      chk("t6_async_pmem_read", pmem_read[0], 0);
      chk("t6_async_pmem_address", pmem_address[0], 0);
      chk("t6_async_pmem_wdata", pmem_wdata[0], 0);
      chk("t6_async_i_resp", i_resp[0], 0);
      chk("t6_async_d_resp", d_resp[0], 0);
      clear_inputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      mem_lat[0] = 2;
      tick();
      req_i(0, 1'b1, 1'b0, 32'h0000_7000, '0);
      push(0, {1'b0, 1'b0, 32'h0000_7000, 16'h0000});
      tick();
      chk("t6_fresh_pmem_read", pmem_read[0], 1);
      chk("t6_fresh_pmem_address", pmem_address[0], 32'h0000_7000);
      wait_idle(0);

      // every expected transaction must have completed
      repeat (2) tick();
      chk("q0_drained", exp_q0.size(), 0);
      chk("q1_drained", exp_q1.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
